aes_inv_cipher_iter: RTL and testbench

//  Iterative AES inverse cipher (FIPS-197 InvCipher): one ciphertext block in, one plaintext block out.

---
 rtl/aes_inv_cipher_iter.sv | 155 +++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock. Round keys come from
// an external expansion store addressed by o_rk_idx and returned combinationally on i_rk.
module aes_inv_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse affine map, then GF(2^8) inverse as x^254 = prod x^(2^k), k=1..7.
  function automatic logic [7:0] inv_s(input logic [7:0] a);
    logic [7:0] t, sq, acc;
    t   = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    sq  = t;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  assign o_y = inv_s(i_a);
endmodule

module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_ct,
  output logic [3:0]   o_rk_idx,
  input  logic [127:0] i_rk,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_pt,
  output logic         o_busy
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;
  localparam logic [3:0] LP_NR = 4'(NR);

  fsm_t         r_fsm, w_fsm_nxt;
  logic [127:0] r_state, w_state_nxt;
  logic [3:0]   r_round, w_round_nxt;
  logic [3:0]   r_rk_idx, w_rk_idx_nxt;
  logic [127:0] w_isr, w_isb, w_ark, w_imc;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // {0e,0b,0d,09} circulant built from the x2/x4/x8 xtime chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0]  a [4];
    logic [7:0]  m9 [4];
    logic [7:0]  mb [4];
    logic [7:0]  md [4];
    logic [7:0]  me [4];
    logic [7:0]  x2, x4, x8;
    logic [31:0] o;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    o = 32'h0;
    for (int i = 0; i < 4; i++)
      o[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    return o;
  endfunction

  // Byte b = r + 4c sits at [127-8b]; InvShiftRows moves row r right by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = r + 4*c;
      localparam int SRC = r + 4*((c - r + 4) % 4);
      assign w_isr[127-8*DST -: 8] = r_state[127-8*SRC -: 8];
      aes_inv_sbox u_sbox (.i_a(w_isr[127-8*DST -: 8]), .o_y(w_isb[127-8*DST -: 8]));
    end
    assign w_imc[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
  end

  assign w_ark = w_isb ^ i_rk;

  always_comb begin
    w_fsm_nxt    = r_fsm;
    w_state_nxt  = r_state;
    w_round_nxt  = r_round;
    w_rk_idx_nxt = r_rk_idx;
    case (r_fsm)
      IDLE: if (i_in_valid) begin
        w_state_nxt  = i_ct ^ i_rk;
        w_round_nxt  = LP_NR - 4'd1;
        w_rk_idx_nxt = LP_NR - 4'd1;
        w_fsm_nxt    = ROUND;
      end
      ROUND: begin
        w_state_nxt = w_imc;
        if (r_round == 4'd1) begin
          w_fsm_nxt    = FINAL;
          w_rk_idx_nxt = 4'd0;
        end else begin
          w_round_nxt  = r_round - 4'd1;
          w_rk_idx_nxt = r_round - 4'd1;
        end
      end
      FINAL: begin
        w_state_nxt  = w_ark;
        w_rk_idx_nxt = 4'd0;
        w_fsm_nxt    = DONE;
      end
      DONE: if (i_out_ready) begin
        w_fsm_nxt    = IDLE;
        w_round_nxt  = LP_NR;
        w_rk_idx_nxt = LP_NR;
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fsm    <= IDLE;
      r_state  <= 128'h0;
      r_round  <= LP_NR;
      r_rk_idx <= LP_NR;
    end else begin
      r_fsm    <= w_fsm_nxt;
      r_state  <= w_state_nxt;
      r_round  <= w_round_nxt;
      r_rk_idx <= w_rk_idx_nxt;
    end
  end

  assign o_in_ready  = (r_fsm == IDLE);
  assign o_out_valid = (r_fsm == DONE);
  assign o_busy      = (r_fsm != IDLE);
  assign o_pt        = r_state;
  assign o_rk_idx    = r_rk_idx;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: known FIPS-197 vectors plus random blocks checked
// against a forward-cipher reference (encrypt random pt, expect the DUT to recover it).
module tb_aes_inv_cipher_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [127:0] a_ct, a_rk, a_pt;
  logic [3:0]   a_rk_idx;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [127:0] b_ct, b_rk, b_pt;
  logic [3:0]   b_rk_idx;

  logic [127:0] rk10_tab [0:15];
  logic [127:0] rk14_tab [0:15];
  logic [127:0] ek [0:15];
  logic [7:0]   sbox [0:255];

  assign a_rk = rk10_tab[a_rk_idx];
  assign b_rk = rk14_tab[b_rk_idx];

  aes_inv_cipher_iter #(.NR(10)) u_dut10 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(a_in_valid), .o_in_ready(a_in_ready),
    .i_ct(a_ct), .o_rk_idx(a_rk_idx), .i_rk(a_rk), .o_out_valid(a_out_valid),
    .i_out_ready(a_out_ready), .o_pt(a_pt), .o_busy(a_busy));

  aes_inv_cipher_iter #(.NR(14)) u_dut14 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
    .i_ct(b_ct), .o_rk_idx(b_rk_idx), .i_rk(b_rk), .o_out_valid(b_out_valid),
    .i_out_ready(b_out_ready), .o_pt(b_pt), .o_busy(b_busy));

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk);
    logic [31:0] w [0:63];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 64; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      ek[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
    logic [127:0] s, t;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ ek[0];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++)
          s[127-8*(rr+4*c) -: 8] = t[127-8*(rr+4*((c+rr)%4)) -: 8];
      if (r != nr)
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
          s[127-32*c -: 8] = gf_mul(a0, 2) ^ gf_mul(a1, 3) ^ a2 ^ a3;
          s[119-32*c -: 8] = a0 ^ gf_mul(a1, 2) ^ gf_mul(a2, 3) ^ a3;
          s[111-32*c -: 8] = a0 ^ a1 ^ gf_mul(a2, 2) ^ gf_mul(a3, 3);
          s[103-32*c -: 8] = gf_mul(a0, 3) ^ a1 ^ a2 ^ gf_mul(a3, 2);
        end
      s = s ^ ek[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- drivers ----------------
  task automatic load_key10(input logic [127:0] key);
    expand_key({key, 128'h0}, 4);
    for (int r = 0; r < 16; r++) rk10_tab[r] = ek[r];
  endtask

  task automatic load_key14(input logic [255:0] key);
    expand_key(key, 8);
    for (int r = 0; r < 16; r++) rk14_tab[r] = ek[r];
  endtask

  task automatic send_a(input logic [127:0] ct);
    a_in_valid = 1'b1;
    a_ct = ct;
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen; -1 on timeout.
  task automatic wait_a(output int n);
    n = 0;
    while (!a_out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!a_out_valid) n = -1;
  endtask

  task automatic release_a();
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (a_in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready: got %b want 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid: got %b want 0", a_out_valid); end
    checks++; if (a_pt !== 128'h0) begin errs++; $display("FAIL rst_pt: got %h want 0", a_pt); end
    checks++; if (a_busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", a_busy); end
    checks++; if (a_rk_idx !== 4'd10) begin errs++; $display("FAIL rst_rk_idx10: got %0d want 10", a_rk_idx); end
    checks++; if (b_rk_idx !== 4'd14) begin errs++; $display("FAIL rst_rk_idx14: got %0d want 14", b_rk_idx); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_c1();
    int n;
    load_key10(C1_KEY);
    send_a(C1_CT);
    wait_a(n);
    checks++; if (n !== 10) begin errs++; $display("FAIL c1_latency: got %0d edges want 10", n); end
    checks++; if (a_pt !== C1_PT) begin errs++; $display("FAIL c1_pt: got %h want %h", a_pt, C1_PT); end
    checks++; if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin
      errs++; $display("FAIL c1_done_flags: got busy=%b in_ready=%b want 1/0", a_busy, a_in_ready); end
    release_a();
    checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
      errs++; $display("FAIL c1_back_idle: got in_ready=%b out_valid=%b busy=%b want 1/0/0",
                       a_in_ready, a_out_valid, a_busy); end
  endtask

  task automatic test_appb();
    int n;
    load_key10(B_KEY);
    send_a(B_CT);
    wait_a(n);
    checks++; if (a_pt !== B_PT) begin errs++; $display("FAIL appb_pt: got %h want %h", a_pt, B_PT); end
    release_a();
  endtask

  task automatic test_rk_seq();
    int exp_idx;
    load_key10(C1_KEY);
    checks++; if (a_rk_idx !== 4'd10) begin errs++; $display("FAIL rkseq_idle: got %0d want 10", a_rk_idx); end
    send_a(C1_CT);
    for (int k = 0; k <= 10; k++) begin
      exp_idx = (k <= 8) ? 9 - k : 0;
      checks++; if (a_rk_idx !== 4'(exp_idx)) begin
        errs++; $display("FAIL rkseq_k%0d: got %0d want %0d", k, a_rk_idx, exp_idx); end
      checks++; if (a_in_ready !== 1'b0) begin
        errs++; $display("FAIL rkseq_in_ready_k%0d: got %b want 0", k, a_in_ready); end
      if (k == 3) begin a_in_valid = 1'b1; a_ct = rnd128(); end
      if (k == 4) a_in_valid = 1'b0;
      if (k < 10) @(negedge clk);
    end
    checks++; if (a_out_valid !== 1'b1 || a_pt !== C1_PT) begin
      errs++; $display("FAIL rkseq_ignored_in: got ov=%b pt=%h want 1 %h", a_out_valid, a_pt, C1_PT); end
    release_a();
  endtask

  task automatic test_backpressure();
    logic [127:0] pt, ct;
    int n;
    load_key10(rnd128());
    pt = rnd128();
    ct = encrypt(pt, 10);
    send_a(ct);
    wait_a(n);
    checks++; if (n !== 10) begin errs++; $display("FAIL bp_latency: got %0d want 10", n); end
    a_in_valid = 1'b1;
    a_ct = rnd128();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_pt !== pt) begin
        errs++; $display("FAIL bp_hold_%0d: got ov=%b ir=%b pt=%h want 1 0 %h", i, a_out_valid, a_in_ready, a_pt, pt); end
    end
    a_in_valid = 1'b0;
    release_a();
    checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      errs++; $display("FAIL bp_release: got ir=%b ov=%b want 1 0", a_in_ready, a_out_valid); end
  endtask

  task automatic test_reset_mid();
    int n;
    load_key10(C1_KEY);
    send_a(C1_CT);
    repeat (4) @(negedge clk);
    checks++; if (a_rk_idx !== 4'd5) begin errs++; $display("FAIL rmid_round: got %0d want 5", a_rk_idx); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_rk_idx !== 4'd10) begin
      errs++; $display("FAIL rmid_flags: got ir=%b ov=%b busy=%b idx=%0d want 1 0 0 10",
                       a_in_ready, a_out_valid, a_busy, a_rk_idx); end
    checks++; if (a_pt !== 128'h0) begin errs++; $display("FAIL rmid_pt: got %h want 0", a_pt); end
    send_a(C1_CT);
    wait_a(n);
    checks++; if (a_pt !== C1_PT || n !== 10) begin
      errs++; $display("FAIL rmid_rerun: got pt=%h n=%0d want %h 10", a_pt, n, C1_PT); end
    release_a();
  endtask

  task automatic test_inv_shift_rows();
    int n;
    for (int r = 0; r < 16; r++) rk10_tab[r] = 128'h0;
    send_a(128'hd4bf5d30e0b452aeb84111f11e2798e5);
    checks++; if (u_dut10.w_isr !== 128'hd42711aee0bf98f1b8b45de51e415230) begin
      errs++; $display("FAIL isr_unit: got %h want d42711aee0bf98f1b8b45de51e415230", u_dut10.w_isr); end
    wait_a(n);
    checks++; if (n !== 10) begin errs++; $display("FAIL isr_drain: got %0d want 10", n); end
    release_a();
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt, ct;
    int n;
    int unsigned t_acc, t_prev;
    t_prev = 0;
    a_out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      load_key10(rnd128());
      pt = rnd128();
      ct = encrypt(pt, 10);
      checks++; if (a_in_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready_%0d: got %b want 1", b, a_in_ready); end
      t_acc = cyc;
      send_a(ct);
      wait_a(n);
      checks++; if (a_pt !== pt) begin errs++; $display("FAIL b2b_pt_%0d: got %h want %h", b, a_pt, pt); end
      if (b > 0) begin
        checks++; if (t_acc - t_prev !== 12) begin
          errs++; $display("FAIL b2b_period_%0d: got %0d want 12", b, t_acc - t_prev); end
      end
      t_prev = t_acc;
      @(negedge clk);
    end
    a_out_ready = 1'b0;
  endtask

  task automatic test_nr14();
    logic [127:0] pt, ct;
    int n;
    for (int b = 0; b < 4; b++) begin
      if (b == 0) begin
        load_key14(C3_KEY);
        pt = C1_PT;
        ct = C3_CT;
      end else begin
        load_key14({rnd128(), rnd128()});
        pt = rnd128();
        ct = encrypt(pt, 14);
      end
      b_in_valid = 1'b1;
      b_ct = ct;
      @(negedge clk);
      b_in_valid = 1'b0;
      n = 0;
      while (!b_out_valid && n < 100) begin @(negedge clk); n++; end
      checks++; if (n !== 14) begin errs++; $display("FAIL nr14_latency_%0d: got %0d want 14", b, n); end
      checks++; if (b_pt !== pt) begin errs++; $display("FAIL nr14_pt_%0d: got %h want %h", b, b_pt, pt); end
      b_out_ready = 1'b1;
      @(negedge clk);
      b_out_ready = 1'b0;
    end
  endtask

  initial begin
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_ct = 128'h0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_ct = 128'h0;
    for (int r = 0; r < 16; r++) begin rk10_tab[r] = 128'h0; rk14_tab[r] = 128'h0; end
    build_sbox();
    @(negedge clk);
    test_reset();
    test_c1();
    test_appb();
    test_rk_seq();
    test_backpressure();
    test_reset_mid();
    test_inv_shift_rows();
    test_back_to_back();
    test_nr14();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
